pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline stage register, the successor to the fixed-field stage latches between EX/MEM/WB.
- Carries one opaque payload bus of DATA_W bits with a valid/ready handshake, synchronous flush, and a 1-entry skid buffer.
- Downstream back-pressure therefore never combinationally reaches upstream ready.
- Instantiated once per stage boundary; stage-specific fields are packed and unpacked outside it.

Parameters:
- DATA_W, 32, payload width in bits (1..1024).
- RESET_VAL, '0 (DATA_W bits), value loaded into both data registers on reset and on a clearing flush.
- FLUSH_CLR_DATA, 1, 1: flush also loads RESET_VAL into the data registers; 0: flush clears valid bits only.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload of the oldest held entry.

Behaviour:
- Storage: main (main_v, main_d) and skid (skid_v, skid_d). out_valid = main_v, out_data = main_d, in_ready = !skid_v.
- Transfer conditions: acc_in = in_valid && in_ready; acc_out = main_v && out_ready.
- States: EMPTY (main_v=0, skid_v=0), ONE (1,0), FULL (1,1). State (0,1) is illegal and must never occur.
- EMPTY: on acc_in, main <= in_data, go to ONE.
- ONE, acc_in && acc_out: main <= in_data, stay in ONE. This is a full-throughput pass, 1-cycle latency.
- ONE, acc_in only: skid <= in_data, go to FULL; in_ready drops on the next cycle.
- ONE, acc_out only: go to EMPTY.
- FULL: acc_in is impossible. On acc_out, main <= skid_d, skid_v <= 0, go to ONE.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by flush.
- Latency is 1 cycle from in accept to out_valid when EMPTY. Sustained throughput is 1 per cycle while out_ready=1.
- Flush has priority over all other events in the same cycle:
  - main_v <= 0, skid_v <= 0.
  - If FLUSH_CLR_DATA, main_d and skid_d <= RESET_VAL.
  - A concurrent in_valid is dropped and not accepted, even though in_ready was 1; upstream must treat it as flushed.
  - in_ready reads 1 the cycle after flush.
- Reset: main_v=0, skid_v=0, main_d=skid_d=RESET_VAL. Hence out_valid=0, out_data=RESET_VAL, in_ready=1. Assertion mid-transfer discards everything immediately, asynchronously.
- out_data is don't-care when out_valid=0, except that after reset or a clearing flush it must equal RESET_VAL (this is the bubble value decoded downstream).
- in_data is only sampled on acc_in. Payload changes while stalled are ignored.

Optional Feature:
- PIPE_STAGE_STATS_EN defined adds three ports:
  - stall_cnt out 32: cycles with out_valid && !out_ready.
  - bubble_cnt out 32: cycles with !out_valid.
  - flush_cnt out 16: flush pulses.
- All counters saturate at max, clear on Rst only, and are not affected by flush.
- Without the macro, the ports and logic are absent and the RTL has identical handshake behaviour.

Decomposition:
- Package pipe_pkg: state enum {PS_EMPTY, PS_ONE, PS_FULL}, STATS_CNT_W=32, FLUSH_CNT_W=16, and a saturating-increment function.
- Natural sub-module: pipe_stage_stats (the counters, instantiated under the macro).
- The core stays flat, with two data registers plus one state register.

Test Plan:
- Reset with DATA_W=32, RESET_VAL=32'hDEAD_BEEF -> out_valid=0, out_data=32'hDEAD_BEEF, in_ready=1 immediately on Rst rise (async, no clock).
- Stream 0x1..0x8 with out_ready=1 -> out_data=0x1..0x8 on consecutive cycles, 1 cycle behind input, in_ready constantly 1.
- out_ready=0, push 0xA then 0xB -> FULL, in_ready=0 next cycle. Raise out_ready -> 0xA then 0xB out in order, in_ready=1 one cycle after 0xA leaves.
- FULL state plus flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=RESET_VAL, 0xC never appears, in_ready=1.
- FLUSH_CLR_DATA=0, hold 0x55 then flush -> out_valid=0, out_data stays 0x55.
- With PIPE_STAGE_STATS_EN: 10 cycles out_ready=0 with valid held, then 3 flushes -> stall_cnt=10, flush_cnt=3. Force stall_cnt near 32'hFFFF_FFFF -> saturates, no wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_stage_skid pipeline register and its
// optional statistics counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int STATS_CNT_W = 32;
    localparam int FLUSH_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_stats.sv
// Saturating activity counters for one pipeline stage boundary: stall cycles,
// bubble cycles and flush pulses. Cleared by Rst only; flush leaves them alone.
module pipe_stage_skid_stats
    import pipe_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   flush,
    input  logic                   out_valid,
    input  logic                   out_ready,
    output logic [STATS_CNT_W-1:0] stall_cnt,
    output logic [STATS_CNT_W-1:0] bubble_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);

    logic [STATS_CNT_W-1:0] stall_cnt_q;
    logic [STATS_CNT_W-1:0] bubble_cnt_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (!out_valid)              bubble_cnt_q <= sat_inc(bubble_cnt_q);
            if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline register with a 1-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to add the stall/bubble/flush counter ports.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] RESET_VAL      = '0,
    parameter bit                FLUSH_CLR_DATA = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0] stall_cnt,
    output logic [STATS_CNT_W-1:0] bubble_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
`endif
);

    // Handshake: a transfer happens on an edge where valid && ready are both 1.
    // in_ready depends only on registered state, so downstream stalls never
    // reach upstream combinationally.
    pipe_state_e       state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              acc_in;
    logic              acc_out;

    assign out_valid = (state_q != PS_EMPTY);
    assign in_ready  = (state_q != PS_FULL);
    assign out_data  = main_q;
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = out_valid && out_ready;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= PS_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else if (flush) begin
            // Any payload offered in the flush cycle is dropped.
            state_q <= PS_EMPTY;
            if (FLUSH_CLR_DATA) begin
                main_q <= RESET_VAL;
                skid_q <= RESET_VAL;
            end
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (acc_in) begin
                        main_q  <= in_data;
                        state_q <= PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (acc_in && acc_out) begin
                        main_q <= in_data;
                    end else if (acc_in) begin
                        skid_q  <= in_data;
                        state_q <= PS_FULL;
                    end else if (acc_out) begin
                        state_q <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (acc_out) begin
                        main_q  <= skid_q;
                        state_q <= PS_ONE;
                    end
                end
                default: state_q <= PS_EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_skid_stats u_stats (
        .Clk        (Clk),
        .Rst        (Rst),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: clearing-flush instance driven from a
// vector table, plus a non-clearing instance and optional counter checks.
module tb_pipe_stage_skid;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        Clk;
    logic        Rst;
    logic        a_flush, a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_d, a_od;
    logic        b_flush, b_iv, b_ir, b_ov, b_or;
    logic [31:0] b_d, b_od;
    int          n_checks;
    int          n_errs;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] a_stall, a_bubble, b_stall, b_bubble;
    logic [15:0] a_fcnt, b_fcnt;
`endif

    pipe_stage_skid #(.DATA_W(32), .RESET_VAL(RV), .FLUSH_CLR_DATA(1'b1)) dut_a (
        .Clk(Clk), .Rst(Rst), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(a_stall), .bubble_cnt(a_bubble), .flush_cnt(a_fcnt)
`endif
    );

    pipe_stage_skid #(.DATA_W(32), .RESET_VAL(32'h0), .FLUSH_CLR_DATA(1'b0)) dut_b (
        .Clk(Clk), .Rst(Rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(b_stall), .bubble_cnt(b_bubble), .flush_cnt(b_fcnt)
`endif
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic        chk_d;
        logic [31:0] e_od;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic e_ov, input logic e_ir,
                                input logic chk_d, input logic [31:0] e_od);
        vec_t v;
        v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.chk_d = chk_d; v.e_od = e_od;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        Rst = 1'b1;
        a_flush = 0; a_iv = 0; a_d = '0; a_or = 0;
        b_flush = 0; b_iv = 0; b_d = '0; b_or = 0;

        // stream 1..8 at full rate, 1-cycle latency
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(0, 1, 32'(i + 1), 1, 1, 1, 1, 32'(i + 1));
        vecs[8]  = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        // back-pressure: A then B fill main+skid, stalled push of F is refused
        vecs[9]  = mk(0, 1, 32'hA,  0, 1, 1, 1, 32'hA);
        vecs[10] = mk(0, 1, 32'hB,  0, 1, 0, 1, 32'hA);
        vecs[11] = mk(0, 1, 32'hF,  0, 1, 0, 1, 32'hA);
        vecs[12] = mk(0, 0, 32'h0,  1, 1, 1, 1, 32'hB);
        vecs[13] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        // flush while FULL with a concurrent push of C
        vecs[14] = mk(0, 1, 32'h11, 0, 1, 1, 1, 32'h11);
        vecs[15] = mk(0, 1, 32'h22, 0, 1, 0, 1, 32'h11);
        vecs[16] = mk(1, 1, 32'hC,  0, 0, 1, 1, RV);
        vecs[17] = mk(0, 0, 32'h0,  1, 0, 1, 1, RV);
        // flush while ONE with in_ready=1: push of 44 is dropped
        vecs[18] = mk(0, 1, 32'h33, 0, 1, 1, 1, 32'h33);
        vecs[19] = mk(1, 1, 32'h44, 1, 0, 1, 1, RV);
        vecs[20] = mk(0, 0, 32'h0,  1, 0, 1, 1, RV);
        // payload changes while stalled are ignored; FULL drain ignores in_valid
        vecs[21] = mk(0, 1, 32'h66, 0, 1, 1, 1, 32'h66);
        vecs[22] = mk(0, 1, 32'h67, 0, 1, 0, 1, 32'h66);
        vecs[23] = mk(0, 0, 32'h99, 0, 1, 0, 1, 32'h66);
        vecs[24] = mk(0, 1, 32'h98, 1, 1, 1, 1, 32'h67);
        vecs[25] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h0);

        // ---------------- reset ----------------
        repeat (2) tick();
        check("rst_out_valid", {31'b0, a_ov}, 32'h0);
        check("rst_out_data",  a_od, RV);
        check("rst_in_ready",  {31'b0, a_ir}, 32'h1);
        check("rst_b_out_data", b_od, 32'h0);
        Rst = 1'b0;

        // load an entry, then assert reset between edges
        a_iv = 1; a_d = 32'h77; a_or = 0;
        tick();
        a_iv = 0;
        check("pre_async_valid", {31'b0, a_ov}, 32'h1);
        check("pre_async_data",  a_od, 32'h77);
        #3 Rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, a_ov}, 32'h0);
        check("async_rst_data",  a_od, RV);
        check("async_rst_ready", {31'b0, a_ir}, 32'h1);
        tick();
        Rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            a_flush = vecs[i].flush;
            a_iv    = vecs[i].iv;
            a_d     = vecs[i].d;
            a_or    = vecs[i].ordy;
            tick();
            check($sformatf("v%0d_out_valid", i), {31'b0, a_ov}, {31'b0, vecs[i].e_ov});
            check($sformatf("v%0d_in_ready", i),  {31'b0, a_ir}, {31'b0, vecs[i].e_ir});
            if (vecs[i].chk_d)
                check($sformatf("v%0d_out_data", i), a_od, vecs[i].e_od);
        end
        a_flush = 0; a_iv = 0; a_d = '0; a_or = 0;

        // ---------------- non-clearing flush ----------------
        b_iv = 1; b_d = 32'h55; b_or = 0;
        tick();
        b_iv = 0;
        check("b_hold_valid", {31'b0, b_ov}, 32'h1);
        check("b_hold_data",  b_od, 32'h55);
        b_flush = 1;
        tick();
        b_flush = 0;
        check("b_flush_valid", {31'b0, b_ov}, 32'h0);
        check("b_flush_data",  b_od, 32'h55);
        check("b_flush_ready", {31'b0, b_ir}, 32'h1);

`ifdef PIPE_STAGE_STATS_EN
        // ---------------- counters ----------------
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        a_iv = 1; a_d = 32'h1; a_or = 0;
        tick();
        a_iv = 0;
        repeat (10) tick();
        a_flush = 1; a_or = 1;
        repeat (3) tick();
        a_flush = 0; a_or = 0;
        check("stall_cnt",  a_stall,  32'd10);
        check("flush_cnt",  {16'b0, a_fcnt}, 32'd3);
        check("bubble_cnt", a_bubble, 32'd3);
        a_iv = 1; a_d = 32'h2;
        tick();
        a_iv = 0;
        force dut_a.u_stats.stall_cnt_q = 32'hFFFF_FFFD;
        #1 release dut_a.u_stats.stall_cnt_q;
        repeat (5) tick();
        check("stall_sat", a_stall, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
